regbank_wb_queue: RTL and testbench

- Write-side initiator for the register bank's single write port.
- Accepts results from execute units over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drains at most one entry per cycle into the bank's write port (write_enable/addr_z/data_z/z_regbank_sel).
- Exposes two pending-write query ports with forwarding, so operand fetch can bypass writes not yet committed to the bank.

---
 rtl/regbank_wb_queue.sv | 135 +++++++++++++
 tb/tb_regbank_wb_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wb_queue.sv
// regbank_wb_queue: FIFO-buffered write-back initiator for the register bank write port, with forwarding queries.
// Define REGBANK_WB_COALESCE_EN to merge a push into a matching tail entry instead of allocating.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_SEL
`define REG_SEL 5
`endif
`ifndef S_REGS
`define S_REGS 1'b0
`endif
`ifndef P_REGS
`define P_REGS 1'b1
`endif
`ifndef NUM_PRED_REGS
`define NUM_PRED_REGS 8
`endif
module regbank_wb_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = `WIDTH,
  parameter int REG_SEL = `REG_SEL
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_SEL-1:0]       in_addr,
  input  logic                     in_bank,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     wb_hold,
  output logic                     wb_write_enable,
  output logic [REG_SEL-1:0]       wb_addr_z,
  output logic [WIDTH-1:0]         wb_data_z,
  output logic                     wb_z_regbank_sel,
  input  logic [REG_SEL-1:0]       q_a_addr,
  input  logic [REG_SEL-1:0]       q_b_addr,
  input  logic                     q_a_bank,
  input  logic                     q_b_bank,
  output logic                     q_a_pending,
  output logic                     q_b_pending,
  output logic [WIDTH-1:0]         q_a_data,
  output logic [WIDTH-1:0]         q_b_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(`NUM_PRED_REGS);
  logic [DEPTH-1:0]   mem_bank;
  logic [REG_SEL-1:0] mem_addr [DEPTH];
  logic [WIDTH-1:0]   mem_data [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr, idx;
  logic               push, pop, merge, alloc;
  logic [1:0]         qbank, qpend;
  logic [REG_SEL-1:0] qaddr [2];
  logic [WIDTH-1:0]   qdata [2];
  function automatic logic same(input logic b0, input logic [REG_SEL-1:0] a0,
                                input logic b1, input logic [REG_SEL-1:0] a1);
    return b0 == b1 && (b0 == `P_REGS ? a0[PW-1:0] == a1[PW-1:0] : a0 == a1);
  endfunction
  function automatic logic [WIDTH-1:0] fwd(input logic b, input logic [WIDTH-1:0] d);
    return b == `P_REGS ? {{(WIDTH-1){1'b0}}, d[0]} : d;
  endfunction
  // count never exceeds DEPTH, so its top bit alone signals full
  assign in_ready = ~count[AW];
  assign push = in_valid & in_ready;
  assign pop = (count != '0) & ~wb_hold;
  assign alloc = push & ~merge;
  assign empty = (count == '0) & ~wb_write_enable;
`ifdef REGBANK_WB_COALESCE_EN
  logic [AW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - AW'(1);
  assign merge = push && count != '0 && !(pop && count == (AW+1)'(1)) &&
                 mem_bank[tail_ptr] == in_bank && mem_addr[tail_ptr] == in_addr;
`else
  assign merge = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      wb_write_enable <= 1'b0;
      wb_addr_z <= '0;
      wb_data_z <= '0;
      wb_z_regbank_sel <= 1'b0;
    end else begin
      wb_write_enable <= pop;
      if (pop) begin
        wb_addr_z <= mem_addr[rd_ptr];
        wb_data_z <= mem_data[rd_ptr];
        wb_z_regbank_sel <= mem_bank[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (alloc) wr_ptr <= wr_ptr + AW'(1);
      count <= count + (AW+1)'(alloc) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_bank[wr_ptr] <= in_bank;
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
`ifdef REGBANK_WB_COALESCE_EN
    if (merge) mem_data[tail_ptr] <= in_data;
`endif
  end
  assign qbank = {q_b_bank, q_a_bank};
  assign qaddr[0] = q_a_addr;
  assign qaddr[1] = q_b_addr;
  // scan oldest to youngest so the youngest match wins; output stage is older than every FIFO entry
  always_comb begin
    qpend = '0;
    qdata[0] = '0;
    qdata[1] = '0;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      if (wb_write_enable && same(wb_z_regbank_sel, wb_addr_z, qbank[p], qaddr[p])) begin
        qpend[p] = 1'b1;
        qdata[p] = fwd(wb_z_regbank_sel, wb_data_z);
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + AW'(i);
        if ((AW+1)'(i) < count && same(mem_bank[idx], mem_addr[idx], qbank[p], qaddr[p])) begin
          qpend[p] = 1'b1;
          qdata[p] = fwd(mem_bank[idx], mem_data[idx]);
        end
      end
    end
  end
  assign q_a_pending = qpend[0];
  assign q_b_pending = qpend[1];
  assign q_a_data = qdata[0];
  assign q_b_data = qdata[1];
endmodule

// File: tb/tb_regbank_wb_queue.sv
// tb_regbank_wb_queue: scenario tests plus randomized traffic against a queue-based model of the write-back queue.
module tb_regbank_wb_queue;
  localparam int DEPTH = 4, WIDTH = 32, RS = 5, PW = 3;
  localparam logic SB = 1'b0, PB = 1'b1;
`ifdef REGBANK_WB_COALESCE_EN
  localparam bit COAL = 1;
`else
  localparam bit COAL = 0;
`endif
  typedef struct {logic bank; logic [RS-1:0] addr; logic [WIDTH-1:0] data;} ent_t;
  logic clk = 0, reset = 1, in_valid = 0, in_bank = 0, wb_hold = 0, q_a_bank = 0, q_b_bank = 0;
  logic [RS-1:0] in_addr = 0, q_a_addr = 0, q_b_addr = 0;
  logic [WIDTH-1:0] in_data = 0;
  logic in_ready, wb_write_enable, wb_z_regbank_sel, q_a_pending, q_b_pending, empty;
  logic [RS-1:0] wb_addr_z;
  logic [WIDTH-1:0] wb_data_z, q_a_data, q_b_data;
  logic [2:0] count;
  ent_t q[$];
  ent_t st = '{0, 0, 0};
  bit st_v = 0;
  int n_chk = 0, n_fail = 0;
  regbank_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_bank(in_bank), .in_data(in_data), .wb_hold(wb_hold), .wb_write_enable(wb_write_enable),
    .wb_addr_z(wb_addr_z), .wb_data_z(wb_data_z), .wb_z_regbank_sel(wb_z_regbank_sel),
    .q_a_addr(q_a_addr), .q_b_addr(q_b_addr), .q_a_bank(q_a_bank), .q_b_bank(q_b_bank),
    .q_a_pending(q_a_pending), .q_b_pending(q_b_pending), .q_a_data(q_a_data), .q_b_data(q_b_data),
    .empty(empty), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic hit(ent_t e, logic b, logic [RS-1:0] a);
    return e.bank == b && (b == PB ? e.addr[PW-1:0] == a[PW-1:0] : e.addr == a);
  endfunction
  function automatic logic [WIDTH-1:0] fv(ent_t e);
    return e.bank == PB ? {31'b0, e.data[0]} : e.data;
  endfunction
  function automatic logic [WIDTH:0] mq(logic b, logic [RS-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--) if (hit(q[i], b, a)) return {1'b1, fv(q[i])};
    if (st_v && hit(st, b, a)) return {1'b1, fv(st)};
    return '0;
  endfunction
  // advance the model by one clock edge using the inputs presented before the edge
  task automatic tick();
    ent_t nq[$];
    ent_t nst, t;
    bit p, pu, co;
    nq = q;
    nst = st;
    p = q.size() > 0 && !wb_hold;
    pu = in_valid && q.size() < DEPTH;
    co = COAL && pu && q.size() > 0 && !(p && q.size() == 1) && q[$].bank == in_bank && q[$].addr == in_addr;
    if (co) begin t = nq.pop_back(); t.data = in_data; nq.push_back(t); end
    if (p) nst = nq.pop_front();
    if (pu && !co) nq.push_back('{in_bank, in_addr, in_data});
    if (reset) begin nq.delete(); nst = '{0, 0, 0}; p = 0; end
    @(posedge clk);
    #1;
    q = nq;
    st = nst;
    st_v = p;
  endtask
  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
    n_chk++;
    if ({wb_write_enable, empty, in_ready, count, q_a_pending, q_b_pending} !== 8'b0_1_1_000_0_0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 01100000", {wb_write_enable, empty, in_ready, count, q_a_pending, q_b_pending});
    end
    n_chk++;
    if ({wb_addr_z, wb_data_z, wb_z_regbank_sel, q_a_data, q_b_data} !== '0) begin
      n_fail++; $display("FAIL reset_values got %h %h %b %h %h exp zeros", wb_addr_z, wb_data_z, wb_z_regbank_sel, q_a_data, q_b_data);
    end
  endtask
  task automatic test_single();
    in_bank = SB; in_addr = 3; in_data = 32'h11; in_valid = 1;
    tick();
    in_valid = 0;
    n_chk++;
    if (wb_write_enable !== 1'b0) begin n_fail++; $display("FAIL single_early_we got %b exp 0", wb_write_enable); end
    tick();
    n_chk++;
    if ({wb_write_enable, wb_addr_z, wb_data_z, wb_z_regbank_sel} !== {1'b1, 5'd3, 32'h11, SB}) begin
      n_fail++; $display("FAIL single_write got we=%b a=%0d d=%h s=%b exp 1 3 11 0", wb_write_enable, wb_addr_z, wb_data_z, wb_z_regbank_sel);
    end
    tick();
    n_chk++;
    if ({wb_write_enable, empty} !== 2'b01) begin n_fail++; $display("FAIL single_done got we=%b empty=%b exp 0 1", wb_write_enable, empty); end
  endtask
  task automatic test_hold_fill();
    ent_t exp[$];
    wb_hold = 1; in_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      in_bank = SB; in_addr = RS'(i + 8); in_data = $urandom;
      exp.push_back('{in_bank, in_addr, in_data});
      tick();
    end
    in_valid = 0;
    n_chk++;
    if ({count, in_ready, wb_write_enable} !== 5'b100_0_0) begin
      n_fail++; $display("FAIL hold_full got count=%0d rdy=%b we=%b exp 4 0 0", count, in_ready, wb_write_enable);
    end
    wb_hold = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_chk++;
      if ({wb_write_enable, wb_addr_z, wb_data_z} !== {1'b1, exp[i].addr, exp[i].data}) begin
        n_fail++; $display("FAIL hold_drain%0d got we=%b a=%0d d=%h exp 1 %0d %h", i, wb_write_enable, wb_addr_z, wb_data_z, exp[i].addr, exp[i].data);
      end
    end
    tick();
    n_chk++;
    if ({wb_write_enable, empty} !== 2'b01) begin n_fail++; $display("FAIL hold_done got we=%b empty=%b exp 0 1", wb_write_enable, empty); end
  endtask
  task automatic test_forward();
    wb_hold = 1; in_valid = 1; in_bank = SB; in_addr = 5;
    in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_valid = 0;
    q_a_bank = SB; q_a_addr = 5; q_b_bank = SB; q_b_addr = 6;
    #1;
    n_chk++;
    if ({q_a_pending, q_a_data} !== {1'b1, 32'hB}) begin n_fail++; $display("FAIL fwd_youngest got %b %h exp 1 b", q_a_pending, q_a_data); end
    n_chk++;
    if ({q_b_pending, q_b_data} !== 33'b0) begin n_fail++; $display("FAIL fwd_miss got %b %h exp 0 0", q_b_pending, q_b_data); end
    wb_hold = 0;
    tick();
    n_chk++;
    if ({q_a_pending, q_a_data} !== {1'b1, 32'hB}) begin n_fail++; $display("FAIL fwd_draining got %b %h exp 1 b", q_a_pending, q_a_data); end
    tick();
    tick();
    n_chk++;
    if (q_a_pending !== 1'b0) begin n_fail++; $display("FAIL fwd_committed got %b exp 0", q_a_pending); end
  endtask
  task automatic test_pred();
    in_valid = 1; in_bank = PB; in_addr = 1; in_data = 32'hFFFF_FFFE;
    tick();
    in_valid = 0;
    q_a_bank = PB; q_a_addr = 1; q_b_bank = PB; q_b_addr = 9;
    #1;
    n_chk++;
    if ({q_a_pending, q_a_data, q_b_pending} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL pred_query got %b %h %b exp 1 0 1", q_a_pending, q_a_data, q_b_pending);
    end
    tick();
    n_chk++;
    if ({wb_write_enable, wb_z_regbank_sel, wb_addr_z, wb_data_z} !== {1'b1, PB, 5'd1, 32'hFFFF_FFFE}) begin
      n_fail++; $display("FAIL pred_write got we=%b s=%b a=%0d d=%h exp 1 1 1 fffffffe", wb_write_enable, wb_z_regbank_sel, wb_addr_z, wb_data_z);
    end
  endtask
  task automatic test_reset_mid();
    in_valid = 1; in_bank = SB;
    for (int i = 0; i < 3; i++) begin in_addr = RS'(20 + i); in_data = $urandom; tick(); end
    in_valid = 0;
    n_chk++;
    if (wb_write_enable !== 1'b1) begin n_fail++; $display("FAIL mid_draining got %b exp 1", wb_write_enable); end
    reset = 1;
    tick();
    reset = 0;
    q_a_bank = SB; q_a_addr = 22; q_b_bank = SB; q_b_addr = 21;
    #1;
    n_chk++;
    if ({wb_write_enable, count, empty, in_ready, q_a_pending, q_b_pending} !== 8'b0_000_1_1_0_0) begin
      n_fail++; $display("FAIL mid_reset got %b exp 00001100", {wb_write_enable, count, empty, in_ready, q_a_pending, q_b_pending});
    end
  endtask
  task automatic test_coalesce();
    int nw = 0;
    logic [WIDTH-1:0] last = '0;
    wb_hold = 1; in_valid = 1; in_bank = SB; in_addr = 7;
    in_data = 1; tick();
    in_data = 2; tick();
    in_valid = 0;
    n_chk++;
    if (count !== 3'(COAL ? 1 : 2)) begin n_fail++; $display("FAIL coal_count got %0d exp %0d", count, COAL ? 1 : 2); end
    wb_hold = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wb_write_enable) begin nw++; last = wb_data_z; end
    end
    n_chk++;
    if (nw !== (COAL ? 1 : 2) || last !== 32'd2) begin n_fail++; $display("FAIL coal_writes got n=%0d last=%h exp n=%0d last=2", nw, last, COAL ? 1 : 2); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic [WIDTH:0] ea, eb;
      reset = $urandom_range(0, 79) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      wb_hold = $urandom_range(0, 3) == 0;
      in_bank = 1'($urandom_range(0, 1));
      in_addr = RS'($urandom_range(0, 3) + 8 * $urandom_range(0, 1));
      in_data = $urandom;
      q_a_bank = 1'($urandom_range(0, 1));
      q_a_addr = RS'($urandom_range(0, 3) + 8 * $urandom_range(0, 1));
      q_b_bank = 1'($urandom_range(0, 1));
      q_b_addr = RS'($urandom_range(0, 3) + 8 * $urandom_range(0, 1));
      tick();
      ea = mq(q_a_bank, q_a_addr);
      eb = mq(q_b_bank, q_b_addr);
      n_chk++;
      if ({wb_write_enable, wb_addr_z, wb_data_z, wb_z_regbank_sel} !== {st_v, st.addr, st.data, st.bank}) begin
        n_fail++; $display("FAIL rnd%0d_port got %b %0d %h %b exp %b %0d %h %b", c, wb_write_enable, wb_addr_z, wb_data_z, wb_z_regbank_sel, st_v, st.addr, st.data, st.bank);
      end
      n_chk++;
      if ({count, in_ready, empty} !== {3'(q.size()), q.size() < DEPTH, q.size() == 0 && !st_v}) begin
        n_fail++; $display("FAIL rnd%0d_status got count=%0d rdy=%b empty=%b exp count=%0d", c, count, in_ready, empty, q.size());
      end
      n_chk++;
      if ({q_a_pending, q_a_data} !== ea) begin n_fail++; $display("FAIL rnd%0d_qa got %b %h exp %b %h", c, q_a_pending, q_a_data, ea[WIDTH], ea[WIDTH-1:0]); end
      n_chk++;
      if ({q_b_pending, q_b_data} !== eb) begin n_fail++; $display("FAIL rnd%0d_qb got %b %h exp %b %h", c, q_b_pending, q_b_data, eb[WIDTH], eb[WIDTH-1:0]); end
    end
    reset = 0; in_valid = 0; wb_hold = 0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_hold_fill();
    test_forward();
    test_pred();
    test_reset_mid();
    test_coalesce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
